// File: rtl/pixel_fetch_if.sv
// Frame-request, BRAM-read and concat-stage signal bundle for pixel_fetch_ctrl.
// master: frame control / concat side; slave: the fetch sequencer.
//   start/abort/hold/base_addr/pix_num : frame request and flow control
//   bram_en/bram_addr                  : BRAM read port
//   cat_rst/cat_ival/cat_oval/cat_ostall/pix_keep : concat stage control
//   busy/done/err                      : status
interface pixel_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              abort;
    logic              hold;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  pix_num;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic              cat_rst;
    logic              cat_ival;
    logic              cat_oval;
    logic              cat_ostall;
    logic              pix_keep;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, abort, hold, base_addr, pix_num,
        output cat_oval, cat_ostall,
        input  bram_en, bram_addr, cat_rst, cat_ival,
        input  pix_keep, busy, done, err
    );

    modport slave (
        input  start, abort, hold, base_addr, pix_num,
        input  cat_oval, cat_ostall,
        output bram_en, bram_addr, cat_rst, cat_ival,
        output pix_keep, busy, done, err
    );
endinterface

// File: rtl/pixel_fetch_ctrl.sv
// BRAM read sequencer for the 32->24 bit pixel concat stage.
// Ports: clk, rst (sync, active-low), bus (pixel_fetch_if.slave: frame
// request, BRAM read port, concat control, busy/done/err status).
module pixel_fetch_ctrl #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    pixel_fetch_if.slave  bus
);

    localparam int WW = CNT_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        ABORT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  pix_cnt;
    logic [WW-1:0]     words_q;
    logic [WW-1:0]     word_idx;
    logic [WW-1:0]     words_c;
    logic [1:0]        grp_cnt;
    logic [1:0]        en_grp;
    logic [1:0]        ival_grp;
    logic              owe;
    logic              bram_en_q;
    logic [ADDR_W-1:0] bram_addr_q;
    logic              ival_q;
    logic              cat_rst_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              in_frame;
    logic              keep_c;
    logic              last_pix;
    logic              can_issue;
    logic              stall_bad;

    // Three words carry four 24-bit pixels.
    assign words_c = (WW'(bus.pix_num) * WW'(3) + WW'(3)) >> 2;

    assign in_frame = (state == FETCH) || (state == DRAIN);
    assign keep_c   = rst && in_frame && bus.cat_oval &&
                      (pix_cnt < num_q);
    assign last_pix = keep_c && ((pix_cnt + CNT_W'(1)) == num_q);

    // owe marks the bubble after word 3k+2; a hold cycle also pays it.
    assign can_issue = (state == FETCH) && !bus.abort && !bus.hold &&
                       !owe && (word_idx < words_q);

    // Concat may only stall while it holds word 3k+2.
    assign stall_bad = bus.cat_ostall && (!ival_q || (ival_grp != 2'd2));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            base_q      <= '0;
            num_q       <= '0;
            words_q     <= '0;
            word_idx    <= '0;
            grp_cnt     <= '0;
            en_grp      <= '0;
            ival_grp    <= '0;
            owe         <= 1'b0;
            pix_cnt     <= '0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            ival_q      <= 1'b0;
            cat_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            bram_en_q <= 1'b0;
            done_q    <= 1'b0;
            cat_rst_q <= 1'b0;
            ival_q    <= bram_en_q;
            ival_grp  <= en_grp;

            if (stall_bad) begin
                err_q <= 1'b1;
            end

            if (can_issue) begin
                bram_en_q   <= 1'b1;
                bram_addr_q <= base_q + ADDR_W'(word_idx);
                en_grp      <= grp_cnt;
                word_idx    <= word_idx + WW'(1);
                grp_cnt     <= (grp_cnt == 2'd2) ? 2'd0 : grp_cnt + 2'd1;
                owe         <= (grp_cnt == 2'd2);
            end else begin
                owe <= 1'b0;
            end

            if (keep_c) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end

            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.pix_num == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state     <= FETCH;
                            busy_q    <= 1'b1;
                            cat_rst_q <= 1'b1;
                            base_q    <= bus.base_addr;
                            num_q     <= bus.pix_num;
                            words_q   <= words_c;
                            pix_cnt   <= '0;
                            owe       <= 1'b0;
                            // Word 0 goes out in the first busy cycle.
                            if (!bus.hold) begin
                                bram_en_q   <= 1'b1;
                                bram_addr_q <= bus.base_addr;
                                en_grp      <= 2'd0;
                                word_idx    <= WW'(1);
                                grp_cnt     <= 2'd1;
                            end else begin
                                word_idx <= '0;
                                grp_cnt  <= 2'd0;
                            end
                        end
                    end
                end
                FETCH: begin
                    if (bus.abort) begin
                        state <= ABORT;
                    end else if (word_idx == words_q) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.abort) begin
                        state <= ABORT;
                    end
                end
                ABORT: begin
                    // In-flight word has landed; flush concat.
                    state     <= IDLE;
                    busy_q    <= 1'b0;
                    cat_rst_q <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (last_pix) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
                state  <= IDLE;
            end
        end
    end

    assign bus.bram_en   = bram_en_q;
    assign bus.bram_addr = bram_addr_q;
    assign bus.cat_rst   = cat_rst_q | ~rst;
    assign bus.cat_ival  = ival_q;
    assign bus.pix_keep  = keep_c;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
// Directed bench for pixel_fetch_ctrl with a behavioural concat model.
// Traces each frame per cycle and checks against hand-derived masks.
module tb_pixel_fetch_ctrl;

    localparam int NT = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pixel_fetch_if #(.ADDR_W(16), .CNT_W(16)) bus();

    pixel_fetch_ctrl #(.ADDR_W(16), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [1:0] wcnt   = 2'd0;
    logic       pend   = 1'b0;
    logic       inject = 1'b0;

    logic [NT-1:0] tr_en, tr_ival, tr_rst, tr_keep;
    logic [NT-1:0] tr_done, tr_busy, tr_err;
    logic [15:0]   tr_addr [NT];

    // Concat model: one pixel per word the cycle after it is presented,
    // plus a leftover pixel after word 3k+2 (during the read bubble).
    assign bus.cat_ostall = inject | (bus.cat_ival & (wcnt == 2'd2));

    always @(posedge clk) begin
        if (bus.cat_rst) begin
            wcnt         <= 2'd0;
            pend         <= 1'b0;
            bus.cat_oval <= 1'b0;
        end else begin
            bus.cat_oval <= bus.cat_ival | pend;
            pend         <= bus.cat_ival & (wcnt == 2'd2);
            if (bus.cat_ival) begin
                wcnt <= (wcnt == 2'd2) ? 2'd0 : wcnt + 2'd1;
            end
        end
    end

    task automatic run_frame(input logic [15:0] base,
                             input logic [15:0] num,
                             input int hold_from, input int hold_len,
                             input int abort_at, input int restart_at,
                             input int inject_at);
        tr_en = '0; tr_ival = '0; tr_rst = '0; tr_keep = '0;
        tr_done = '0; tr_busy = '0; tr_err = '0;
        for (int i = 0; i < NT; i++) tr_addr[i] = '0;
        @(negedge clk);
        bus.base_addr = base;
        bus.pix_num   = num;
        bus.start     = 1'b1;
        for (int k = 1; k < NT; k++) begin
            @(negedge clk);
            bus.start = (k == restart_at);
            if (k == restart_at) bus.base_addr = 16'hAAAA;
            tr_en[k]   = bus.bram_en;
            tr_addr[k] = bus.bram_addr;
            tr_ival[k] = bus.cat_ival;
            tr_rst[k]  = bus.cat_rst;
            tr_keep[k] = bus.pix_keep;
            tr_done[k] = bus.done;
            tr_busy[k] = bus.busy;
            tr_err[k]  = bus.err;
            bus.hold  = (k >= hold_from) && (k < hold_from + hold_len);
            bus.abort = (k == abort_at);
            inject    = (k == inject_at);
        end
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        bus.abort = 1'b0;
        inject    = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.cat_rst !== 1'b1) begin
            bad++;
            $display("FAIL rst_cat_rst got=%b want=1", bus.cat_rst);
        end
        total++;
        if ({bus.bram_en, bus.cat_ival, bus.pix_keep, bus.busy,
             bus.done, bus.err} !== 6'b0) begin
            bad++;
            $display("FAIL rst_outs got=%b want=000000",
                     {bus.bram_en, bus.cat_ival, bus.pix_keep,
                      bus.busy, bus.done, bus.err});
        end
        total++;
        if (bus.bram_addr !== 16'h0) begin
            bad++;
            $display("FAIL rst_addr got=%h want=0000", bus.bram_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.cat_rst !== 1'b0) begin
            bad++;
            $display("FAIL rst_release_cat_rst got=%b want=0", bus.cat_rst);
        end
    endtask

    task automatic test_basic;
        logic [15:0] ea [3];
        ea[0] = 16'h0010; ea[1] = 16'h0011; ea[2] = 16'h0012;
        // restart pulse while busy must be ignored
        run_frame(16'h0010, 16'd4, 0, 0, 0, 3, 0);
        total++;
        if (tr_en !== 24'h00000E) begin
            bad++; $display("FAIL basic_en got=%h want=00000e", tr_en);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (tr_addr[i+1] !== ea[i]) begin
                bad++;
                $display("FAIL basic_addr%0d got=%h want=%h",
                         i, tr_addr[i+1], ea[i]);
            end
        end
        total++;
        if (tr_rst !== 24'h000002) begin
            bad++; $display("FAIL basic_cat_rst got=%h want=000002", tr_rst);
        end
        total++;
        if (tr_ival !== 24'h00001C) begin
            bad++; $display("FAIL basic_ival got=%h want=00001c", tr_ival);
        end
        total++;
        if (tr_keep !== 24'h000078) begin
            bad++; $display("FAIL basic_keep got=%h want=000078", tr_keep);
        end
        total++;
        if (tr_done !== 24'h000080) begin
            bad++; $display("FAIL basic_done got=%h want=000080", tr_done);
        end
        total++;
        if (tr_busy !== 24'h00007E) begin
            bad++; $display("FAIL basic_busy got=%h want=00007e", tr_busy);
        end
        total++;
        if (tr_err !== 24'h0) begin
            bad++; $display("FAIL basic_err got=%h want=000000", tr_err);
        end
    endtask

    task automatic test_wrap;
        run_frame(16'hFFFE, 16'd5, 0, 0, 0, 0, 0);
        total++;
        if (tr_en !== 24'h00002E) begin
            bad++; $display("FAIL wrap_en got=%h want=00002e", tr_en);
        end
        total++;
        if ({tr_addr[1], tr_addr[2], tr_addr[3], tr_addr[5]} !==
            64'hFFFE_FFFF_0000_0001) begin
            bad++;
            $display("FAIL wrap_addr got=%h %h %h %h want=fffe ffff 0000 0001",
                     tr_addr[1], tr_addr[2], tr_addr[3], tr_addr[5]);
        end
        total++;
        if (tr_keep !== 24'h0000F8) begin
            bad++; $display("FAIL wrap_keep got=%h want=0000f8", tr_keep);
        end
        total++;
        if (tr_done !== 24'h000100) begin
            bad++; $display("FAIL wrap_done got=%h want=000100", tr_done);
        end
        total++;
        if (tr_err !== 24'h0) begin
            bad++; $display("FAIL wrap_err got=%h want=000000", tr_err);
        end
    endtask

    task automatic test_surplus;
        run_frame(16'h0040, 16'd3, 0, 0, 0, 0, 0);
        total++;
        if (tr_en !== 24'h00000E) begin
            bad++; $display("FAIL surplus_en got=%h want=00000e", tr_en);
        end
        total++;
        if (tr_keep !== 24'h000038) begin
            bad++; $display("FAIL surplus_keep got=%h want=000038", tr_keep);
        end
        total++;
        if (tr_done !== 24'h000040) begin
            bad++; $display("FAIL surplus_done got=%h want=000040", tr_done);
        end
        total++;
        if (tr_busy !== 24'h00003E) begin
            bad++; $display("FAIL surplus_busy got=%h want=00003e", tr_busy);
        end
    endtask

    task automatic test_zero;
        run_frame(16'h0050, 16'd0, 0, 0, 0, 0, 0);
        total++;
        if (tr_done !== 24'h000002) begin
            bad++; $display("FAIL zero_done got=%h want=000002", tr_done);
        end
        total++;
        if ({tr_en, tr_busy, tr_rst} !== 72'h0) begin
            bad++;
            $display("FAIL zero_quiet got=%h %h %h want=0 0 0",
                     tr_en, tr_busy, tr_rst);
        end
    endtask

    task automatic test_hold;
        logic [4:0]  ik [6];
        ik[0] = 5'd1; ik[1] = 5'd2; ik[2] = 5'd8;
        ik[3] = 5'd10; ik[4] = 5'd11; ik[5] = 5'd12;
        run_frame(16'h0200, 16'd8, 2, 5, 0, 0, 0);
        total++;
        if (tr_en !== 24'h001D06) begin
            bad++; $display("FAIL hold_en got=%h want=001d06", tr_en);
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (tr_addr[ik[i]] !== 16'h0200 + 16'(i)) begin
                bad++;
                $display("FAIL hold_addr%0d got=%h want=%h",
                         i, tr_addr[ik[i]], 16'h0200 + 16'(i));
            end
        end
        total++;
        if (tr_keep !== 24'h00FC18) begin
            bad++; $display("FAIL hold_keep got=%h want=00fc18", tr_keep);
        end
        total++;
        if (tr_done !== 24'h010000) begin
            bad++; $display("FAIL hold_done got=%h want=010000", tr_done);
        end
        total++;
        if (tr_err !== 24'h0) begin
            bad++; $display("FAIL hold_err got=%h want=000000", tr_err);
        end
    endtask

    task automatic test_abort;
        run_frame(16'h0100, 16'd8, 0, 0, 2, 0, 0);
        total++;
        if (tr_en !== 24'h000006) begin
            bad++; $display("FAIL abort_en got=%h want=000006", tr_en);
        end
        total++;
        if (tr_rst !== 24'h000012) begin
            bad++; $display("FAIL abort_cat_rst got=%h want=000012", tr_rst);
        end
        total++;
        if (tr_busy !== 24'h00000E) begin
            bad++; $display("FAIL abort_busy got=%h want=00000e", tr_busy);
        end
        total++;
        if (tr_done !== 24'h0) begin
            bad++; $display("FAIL abort_done got=%h want=000000", tr_done);
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        @(negedge clk);
        bus.base_addr = 16'h0040;
        bus.pix_num   = 16'd8;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.cat_rst !== 1'b1) begin
            bad++; $display("FAIL mid_cat_rst got=%b want=1", bus.cat_rst);
        end
        total++;
        if ({bus.bram_en, bus.cat_ival, bus.busy, bus.done,
             bus.pix_keep, bus.bram_addr} !== 21'h0) begin
            bad++;
            $display("FAIL mid_outs got=%h want=000000",
                     {bus.bram_en, bus.cat_ival, bus.busy, bus.done,
                      bus.pix_keep, bus.bram_addr});
        end
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            seen = seen | bus.bram_en | bus.done | bus.busy;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL mid_quiet got=%b want=0", seen);
        end
        run_frame(16'h0020, 16'd4, 0, 0, 0, 0, 0);
        total++;
        if (tr_en !== 24'h00000E) begin
            bad++; $display("FAIL mid_re_en got=%h want=00000e", tr_en);
        end
        total++;
        if (tr_keep !== 24'h000078) begin
            bad++; $display("FAIL mid_re_keep got=%h want=000078", tr_keep);
        end
        total++;
        if (tr_done !== 24'h000080) begin
            bad++; $display("FAIL mid_re_done got=%h want=000080", tr_done);
        end
    endtask

    task automatic test_stall_err;
        run_frame(16'h0030, 16'd4, 0, 0, 0, 0, 2);
        total++;
        if (tr_err !== 24'hFFFFF8) begin
            bad++; $display("FAIL err_sticky got=%h want=fffff8", tr_err);
        end
        total++;
        if (tr_done !== 24'h000080) begin
            bad++; $display("FAIL err_done got=%h want=000080", tr_done);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.err !== 1'b0) begin
            bad++; $display("FAIL err_clear got=%b want=0", bus.err);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.hold      = 1'b0;
        bus.base_addr = '0;
        bus.pix_num   = '0;
        test_reset;
        test_basic;
        test_wrap;
        test_surplus;
        test_zero;
        test_hold;
        test_abort;
        test_reset_mid;
        test_stall_err;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
